// File: rtl/mdu_pkg.sv
// Shared multiply/divide opcodes and default latencies, also used by the hazard unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mfhi  = 4'd5,
    MDU_mflo  = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_mult) || (op == MDU_multu) ||
           (op == MDU_div)  || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath. Division by zero returns the current
// HI/LO so the commit path can stay unconditional.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Low 64 bits of the extended products are exact for both signednesses.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Select result by op; default holds current HI/LO.
  always_comb begin
    hi_res = hi_cur;
    lo_res = lo_cur;
    case (op)
      MDU_mult:  {hi_res, lo_res} = prod_s;
      MDU_multu: {hi_res, lo_res} = prod_u;
      MDU_div: begin
        if (b != 32'd0) begin
          // Most-negative / -1 overflows; pin it to the wrapped quotient.
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo_res = a;
            hi_res = 32'd0;
          end else begin
            lo_res = $signed(a) / $signed(b);
            hi_res = $signed(a) % $signed(b);
          end
        end
      end
      MDU_divu: begin
        if (b != 32'd0) begin
          lo_res = a / b;
          hi_res = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO owner, busy countdown, mt/mf handling.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_tmp, lo_tmp;
  logic [31:0]      hi_res, lo_res;
  logic             acc;
  logic             is_mul;

  mdu_arith u_arith (
    .op     (MDUop),
    .a      (A),
    .b      (B),
    .hi_cur (HI),
    .lo_cur (LO),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign busy   = (cnt != '0);
  assign acc    = !req && !busy && reset;
  assign start  = acc && is_md_op(MDUop);
  assign is_mul = (MDUop == MDU_mult) || (MDUop == MDU_multu);

  // Launch, count down and commit; mt writes only when the unit is idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      HI     <= '0;
      LO     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
    end else if (start) begin
      hi_tmp <= hi_res;
      lo_tmp <= lo_res;
      cnt    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
    end else if (acc) begin
      if (MDUop == MDU_mthi) HI <= A;
      if (MDUop == MDU_mtlo) LO <= A;
    end
  end

  // Move-from read port; zero for every other op.
  always_comb begin
    MDUout = '0;
    if (MDUop == MDU_mfhi) MDUout = HI;
    if (MDUop == MDU_mflo) MDUout = LO;
  end

endmodule
